// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, the default memory depth and the
// address range/alignment check used when a transaction is latched.
package dm_arbiter_pkg;

    // Arbiter FSM states; encodings are fixed so that debug dumps stay readable
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Default data-memory depth in 32-bit words
    localparam int unsigned DM_MEM_WORDS_DEFAULT = 8192;

    // Port identifiers used for the latched winner and the round-robin pointer
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // True when a byte address is not word aligned or points past the memory
    function automatic logic addr_is_bad(input logic [31:0] addr,
                                         input int unsigned mem_words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= mem_words);
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Winner selection for the two-port data-memory arbiter.
// Configuration macro: DM_ARB_FIXED_PRIO_EN -- when defined, port0 always
// wins simultaneous requests and the round-robin pointer is ignored.
module dm_arb_pick
    import dm_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic valid,
    output logic winner
);

`ifdef DM_ARB_FIXED_PRIO_EN
    // The pointer has no meaning with fixed priority; keep it tied off
    logic unused_pointer;
    assign unused_pointer = pointer;

    // Fixed priority: port0 whenever it asks, otherwise port1
    always_comb begin
        valid  = req0 | req1;
        winner = req0 ? PORT0 : PORT1;
    end
`else
    // Round robin: a lone request wins outright, a tie goes to the pointer
    always_comb begin
        valid  = req0 | req1;
        winner = PORT0;
        if (req0 && req1) begin
            winner = pointer;
        end else if (req1) begin
            winner = PORT1;
        end
    end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Each transaction takes IDLE -> ACCESS -> RESP; requests are only looked at
// in IDLE, so a master that keeps req high simply queues its next access.
// Configuration macro: DM_ARB_FIXED_PRIO_EN selects fixed port0 priority
// instead of round-robin arbitration (see dm_arb_pick).
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DM_MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    arb_state_t  state_q;
    arb_state_t  state_d;
    logic        rr_ptr_q;
    logic        lat_port_q;
    logic        lat_we_q;
    logic        lat_err_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        pick_valid;
    logic        pick_winner;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    dm_arb_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .pointer (rr_ptr_q),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    // Route the winning port's request fields toward the transaction latch
    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (pick_winner == PORT1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // State register plus the latched transaction and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= PORT0;
            lat_port_q  <= PORT0;
            lat_we_q    <= 1'b0;
            lat_err_q   <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && pick_valid) begin
                lat_port_q  <= pick_winner;
                lat_we_q    <= sel_we;
                lat_err_q   <= addr_is_bad(sel_addr, MEM_WORDS);
                lat_addr_q  <= sel_addr;
                lat_wdata_q <= sel_wdata;
                rr_ptr_q    <= ~pick_winner;
            end
        end
    end

    // Capture read data for the winner at the end of ACCESS; errors read as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if ((state_q == ST_ACCESS) && !lat_we_q) begin
            if (lat_port_q == PORT1) begin
                rdata1_q <= lat_err_q ? 32'h0 : mem_rdata;
            end else begin
                rdata0_q <= lat_err_q ? 32'h0 : mem_rdata;
            end
        end
    end

    // Next-state logic and cycle outputs; reset gates the write and the done pulse
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        err0    = 1'b0;
        err1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we  = lat_we_q & ~lat_err_q & ~reset;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!reset) begin
                    done0 = (lat_port_q == PORT0);
                    done1 = (lat_port_q == PORT1);
                    err0  = (lat_port_q == PORT0) & lat_err_q;
                    err1  = (lat_port_q == PORT1) & lat_err_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = lat_addr_q;
    assign mem_wdata = lat_wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural memory.
// Build with DM_ARB_FIXED_PRIO_EN defined to exercise fixed-priority grants.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:8191];
    logic        memClear;

    dm_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, write on posedge
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 8192; i++) mem[i] <= '0;
        end else if (mem_we && (mem_addr[31:15] == 17'd0)) begin
            mem[mem_addr[14:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr[31:15] == 17'd0) ? mem[mem_addr[14:2]] : 32'hBAD0_BAD0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    // One full transaction from IDLE; inputs are scrambled during ACCESS
    task automatic transact(input string tag, input logic port, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic expErr, input logic chkRd,
                            input logic [31:0] expRd);
        if (port) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, we, addr, wdata);
        else      applyStimulus(1'b1, we, addr, wdata, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF1, 32'h5555_5555,
                      1'b0, 1'b1, 32'hFFFF_FFF1, 32'h5555_5555);
        #1;
        checkOutput({tag, " access busy"}, busy, 1);
        checkOutput({tag, " access mem_we"}, mem_we, we & ~expErr);
        checkOutput({tag, " access mem_addr"}, mem_addr, addr);
        if (we) checkOutput({tag, " access mem_wdata"}, mem_wdata, wdata);
        tick;
        checkOutput({tag, " resp done0"}, done0, !port);
        checkOutput({tag, " resp done1"}, done1, port);
        checkOutput({tag, " resp err"}, port ? err1 : err0, expErr);
        checkOutput({tag, " resp mem_we"}, mem_we, 0);
        checkOutput({tag, " resp mem_addr hold"}, mem_addr, addr);
        if (chkRd) checkOutput({tag, " resp rdata"}, port ? rdata1 : rdata0, expRd);
        tick;
        checkOutput({tag, " idle busy"}, busy, 0);
        checkOutput({tag, " idle done"}, done0 | done1, 0);
    endtask

    initial begin
        logic expWin;
        reset    = 1'b1;
        memClear = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;
        memClear = 1'b0;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", {done0, done1, err0, err1}, 0);
        checkOutput("reset mem_we", mem_we, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_wdata", mem_wdata, 0);
        checkOutput("reset rdata0", rdata0, 0);
        checkOutput("reset rdata1", rdata1, 0);
        reset = 1'b0;
        tick;

        transact("wr0 0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        transact("rd0 0x10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        transact("wr1 misaligned", 1'b1, 1'b1, 32'h13, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0);
        transact("rd0 after bad wr", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        transact("rd1 0x10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        transact("rd1 out of range", 1'b1, 1'b0, 32'h8000, 32'h0, 1'b1, 1'b1, 32'h0);
        checkOutput("rdata0 hold", rdata0, 32'hDEADBEEF);
        transact("wr1 last word", 1'b1, 1'b1, 32'h7FFC, 32'h12345678, 1'b0, 1'b0, 32'h0);
        checkOutput("rdata1 hold on write", rdata1, 32'h0);
        transact("rd0 last word", 1'b0, 1'b0, 32'h7FFC, 32'h0, 1'b0, 1'b1, 32'h12345678);

        // Reset landing in the ACCESS cycle of a write
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("rstA mem_we", mem_we, 0);
        tick;
        reset = 1'b0;
        #1;
        checkOutput("rstA busy", busy, 0);
        checkOutput("rstA done0", done0, 0);
        checkOutput("rstA mem_addr", mem_addr, 0);
        checkOutput("rstA rdata0", rdata0, 0);
        tick;
        transact("rd0 reload", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        transact("rd0 0x20 unwritten", 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h0);

        // Reset landing in the RESP cycle of a write
        applyStimulus(1'b1, 1'b1, 32'h24, 32'h11112222, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        reset = 1'b1;
        #1;
        checkOutput("rstR done0", done0, 0);
        checkOutput("rstR err0", err0, 0);
        tick;
        reset = 1'b0;
        checkOutput("rstR busy", busy, 0);

        // Both ports held high across six transactions, pointer fresh from reset
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h7FFC, 32'h0);
        for (int t = 0; t < 6; t++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            expWin = 1'b0;
`else
            expWin = (t % 2) == 1;
`endif
            tick;
            checkOutput($sformatf("grant %0d mem_addr", t), mem_addr,
                        expWin ? 32'h7FFC : 32'h10);
            tick;
            checkOutput($sformatf("grant %0d done0", t), done0, !expWin);
            checkOutput($sformatf("grant %0d done1", t), done1, expWin);
            checkOutput($sformatf("grant %0d rdata", t), expWin ? rdata1 : rdata0,
                        expWin ? 32'h12345678 : 32'hDEADBEEF);
            tick;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        transact("rd1 0x24 after rstR", 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h11112222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 8192, SHALL set the data-memory depth in 32-bit words for range checking.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be synchronous, active-high.
REQ-004 req0/req1  input  1 each  SHALL request access (port0 = CPU M-stage, port1 = secondary master).
REQ-005 we0/we1  input  1 each  SHALL select write (1) or read (0).
REQ-006 addr0/addr1, wdata0/wdata1  input  32 each  SHALL be the byte address and store data.
REQ-007 done0/done1  output  1 each  SHALL pulse one cycle on transaction completion.
REQ-008 err0/err1  output  1 each  SHALL be valid with done; high = misaligned or out-of-range.
REQ-009 rdata0/rdata1  output  32 each  SHALL hold read data, valid with done.
REQ-010 mem_we  output  1; mem_addr, mem_wdata  output  32; mem_rdata  input  32  SHALL form the single-port DM interface (combinational read, write on posedge).
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 FSM states: IDLE, ACCESS, RESP; each transaction SHALL occupy exactly one cycle in ACCESS and one in RESP.
REQ-013 IDLE: if any req high, SHALL pick a winner, latch its we/addr/wdata and port id, go ACCESS; else stay IDLE.
REQ-014 Both req high in IDLE: winner SHALL be the port indicated by the round-robin pointer; the pointer then SHALL point to the other port.
REQ-015 Single req in IDLE: that port SHALL win and the pointer SHALL point to the other port.
REQ-016 ACCESS: mem_addr SHALL equal the latched addr; mem_wdata the latched wdata; mem_we = latched we AND NOT latched error.
REQ-017 Latched error SHALL be set if addr[1:0] != 0 or addr[31:2] >= MEM_WORDS; an erroneous write SHALL NOT modify memory.
REQ-018 ACCESS: mem_rdata SHALL be registered into the winner's rdata (reads only; zero on error); state then SHALL go RESP.
REQ-019 RESP: done and err of the winner SHALL be driven for that cycle only; the other port's done SHALL stay 0; state SHALL return to IDLE.
REQ-020 Outside ACCESS, mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their last values.
REQ-021 rdataN SHALL hold its value until port N's next read completes.
REQ-022 req SHALL be sampled only in IDLE; a req still high in the IDLE after done SHALL be treated as a new request.
REQ-023 Request signals changing during ACCESS/RESP SHALL NOT affect the latched transaction.
REQ-024 Latency: req sampled in IDLE at cycle N -> memory write at end of N+1 -> done at N+2; peak throughput one transaction per 3 cycles.

Reset
REQ-025 reset SHALL force IDLE, pointer to port0, done0/done1/err0/err1/mem_we/busy to 0, rdata0/rdata1/mem_addr/mem_wdata to 0.
REQ-026 reset during ACCESS SHALL suppress the write (mem_we 0 that cycle); reset during RESP SHALL suppress done.

Configuration
REQ-027 Macro DM_ARB_FIXED_PRIO_EN defined: port0 SHALL always win simultaneous requests and the pointer SHALL be unused; undefined: round-robin per REQ-014/015.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the default MEM_WORDS constant.
REQ-029 Winner selection SHALL be a sub-module dm_arb_pick (inputs req0, req1, pointer; outputs valid, winner id).

Verification
REQ-030 reset, then req0=1 we0=1 addr0=0x10 wdata0=0xDEADBEEF -> mem_we=1 one cycle later with mem_addr=0x10; done0=1 err0=0 two cycles after request.
REQ-031 After REQ-030, req0=1 we0=0 addr0=0x10 -> done0 with rdata0=0xDEADBEEF.
REQ-032 req0 and req1 held high across six transactions (round-robin build) -> grant order 0,1,0,1,0,1; with DM_ARB_FIXED_PRIO_EN -> 0,0,0,...
REQ-033 req1=1 we1=1 addr1=0x13 -> mem_we=0 throughout; done1=1 err1=1; a subsequent read of 0x10 returns its prior value.
REQ-034 req1=1 we1=0 addr1=0x8000 (word 8192) -> done1=1 err1=1 rdata1=0.
REQ-035 write to 0x20 issued, reset asserted in ACCESS cycle -> mem_we=0, no done; busy=0 after reset; read of 0x20 returns 0.
